branch_predictor: RTL and testbench

// Fetch-stage branch predictor: the producer of the is_pred_branch bit that the execute-stage

---
 rtl/branch_predictor_pkg.sv | 32 +++
 rtl/branch_predictor_sat_counter2.sv | 25 ++
 rtl/branch_predictor.sv | 144 ++++++++++++++
 tb/tb_branch_predictor.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types for the fetch-stage branch predictor: counter encodings,
// the default-geometry table entry layout and a small decode helper.
package branch_predictor_pkg;

    // 2-bit saturating counter states; the MSB is the taken/not-taken decision.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // Default core geometry (32-bit words, 64 entries).
    localparam int BP_WORD_W  = 32;
    localparam int BP_ENTRIES = 64;
    localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
    localparam int BP_TAG_W   = BP_WORD_W - BP_IDX_W - 2;

    // Table entry at the default geometry. Target low two bits are implied zero.
    typedef struct packed {
        logic                  valid;
        logic [BP_TAG_W-1:0]   tag;
        logic [BP_WORD_W-3:0]  target;
        ctr_e                  ctr;
    } bp_entry;

    // A counter in either taken state predicts taken.
    function automatic logic ctr_predicts_taken(input ctr_e c);
        return c[1];
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Combinational next state of a 2-bit saturating counter: step toward ST on a
// taken outcome, toward SNT on a not-taken outcome, holding at either end.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_e ctr_in,
    input  logic taken,
    output ctr_e ctr_out
);

    // Saturating increment/decrement of the counter.
    always_comb begin
        ctr_out = ctr_in;
        if (taken) begin
            if (ctr_in != ST) begin
                ctr_out = ctr_e'(ctr_in + 2'd1);
            end
        end else begin
            if (ctr_in != SNT) begin
                ctr_out = ctr_e'(ctr_in - 2'd1);
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped table of tagged BTB entries with
// 2-bit saturating direction counters. Lookup is combinational from registered
// state (no bypass of a same-cycle update); training comes from the execute-stage
// resolver for conditional branches only, and is frozen while the core is halted.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int                    word_width = 32,
    parameter int                    entries    = 64,
    parameter logic [word_width-1:0] reset_pc   = '0
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [word_width-1:0] fetch_pc,
    input  logic                  fetch_valid,
    output logic                  pred_taken,
    output logic [word_width-1:0] pred_next_pc,
    input  logic                  upd_valid,
    input  logic                  upd_taken,
    input  logic                  upd_pred,
    input  logic [word_width-1:0] upd_pc,
    input  logic [word_width-1:0] upd_target,
    input  logic                  halt,
    output logic [31:0]           branch_count,
    output logic [31:0]           mispred_count
);

    localparam int IDX_W = $clog2(entries);
    localparam int TAG_W = word_width - IDX_W - 2;
    localparam int TGT_W = word_width - 2;

    // Entry layout sized to this instance's geometry (matches bp_entry at defaults).
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [TGT_W-1:0] target;
        ctr_e             ctr;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};

    entry_t      table_q [entries];
    entry_t      table_d [entries];
    logic [31:0] branch_count_q;
    logic [31:0] branch_count_d;
    logic [31:0] mispred_count_q;
    logic [31:0] mispred_count_d;

    // Word-alignment bits and reset_pc carry no information for this block.
    logic unused_bits;
    assign unused_bits = ^{fetch_pc[1:0], upd_pc[1:0], upd_target[1:0], reset_pc};

    // ---------------- lookup side ----------------
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    entry_t           f_entry;
    logic             f_hit;

    assign f_idx   = fetch_pc[IDX_W+1:2];
    assign f_tag   = fetch_pc[word_width-1:IDX_W+2];
    assign f_entry = table_q[f_idx];
    assign f_hit   = f_entry.valid && (f_entry.tag == f_tag);

    // Prediction from pre-update table state; fall through to the sequential PC otherwise.
    always_comb begin
        pred_taken   = fetch_valid && f_hit && ctr_predicts_taken(f_entry.ctr);
        pred_next_pc = pred_taken ? {f_entry.target, 2'b00}
                                  : fetch_pc + word_width'(4);
    end

    // ---------------- update side ----------------
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    entry_t           u_entry;
    logic             u_hit;
    logic             u_fire;
    ctr_e             u_ctr_next;

    assign u_idx   = upd_pc[IDX_W+1:2];
    assign u_tag   = upd_pc[word_width-1:IDX_W+2];
    assign u_entry = table_q[u_idx];
    assign u_hit   = u_entry.valid && (u_entry.tag == u_tag);
    assign u_fire  = upd_valid && !halt;

    sat_counter2 u_sat_counter2 (
        .ctr_in  (u_entry.ctr),
        .taken   (upd_taken),
        .ctr_out (u_ctr_next)
    );

    // Train the indexed entry: adjust on tag hit, allocate weakly-taken on a taken miss.
    always_comb begin
        for (int i = 0; i < entries; i++) begin
            table_d[i] = table_q[i];
        end
        if (u_fire) begin
            if (u_hit) begin
                table_d[u_idx].ctr = u_ctr_next;
                if (upd_taken) begin
                    table_d[u_idx].target = upd_target[word_width-1:2];
                end
            end else if (upd_taken) begin
                table_d[u_idx] = '{valid:  1'b1,
                                   tag:    u_tag,
                                   target: upd_target[word_width-1:2],
                                   ctr:    WT};
            end
        end
    end

    // Resolved-branch and misprediction counters; both wrap freely.
    always_comb begin
        branch_count_d  = branch_count_q;
        mispred_count_d = mispred_count_q;
        if (u_fire) begin
            branch_count_d = branch_count_q + 32'd1;
            if (upd_taken != upd_pred) begin
                mispred_count_d = mispred_count_q + 32'd1;
            end
        end
    end

    // State registers with asynchronous clear of the whole table and both counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < entries; i++) begin
                table_q[i] <= RESET_ENTRY;
            end
            branch_count_q  <= '0;
            mispred_count_q <= '0;
        end else begin
            for (int i = 0; i < entries; i++) begin
                table_q[i] <= table_d[i];
            end
            branch_count_q  <= branch_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign branch_count  = branch_count_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor at the default geometry (32-bit, 64 entries).
// A behavioural model of the predictor table lives here and is compared against
// the DUT outputs on every falling edge; directed steps add literal expectations.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic        upd_valid;
    logic        upd_taken;
    logic        upd_pred;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        halt;
    logic [31:0] branch_count;
    logic [31:0] mispred_count;

    int checks_total  = 0;
    int checks_passed = 0;
    bit cmp_en        = 1'b0;

    branch_predictor #(.word_width(32), .entries(64), .reset_pc(32'h0)) dut (
        .clk           (clk),
        .reset         (rst),
        .fetch_pc      (fetch_pc),
        .fetch_valid   (fetch_valid),
        .pred_taken    (pred_taken),
        .pred_next_pc  (pred_next_pc),
        .upd_valid     (upd_valid),
        .upd_taken     (upd_taken),
        .upd_pred      (upd_pred),
        .upd_pc        (upd_pc),
        .upd_target    (upd_target),
        .halt          (halt),
        .branch_count  (branch_count),
        .mispred_count (mispred_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_valid [64];
    logic [31:0] m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_ctr   [64];
    logic [31:0] m_bc;
    logic [31:0] m_mc;

    always @(posedge clk or posedge rst) begin : model_upd
        int          idx;
        logic [31:0] tag;
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                m_valid[i] = 1'b0;
                m_tag[i]   = 32'h0;
                m_tgt[i]   = 32'h0;
                m_ctr[i]   = 1;
            end
            m_bc = 32'h0;
            m_mc = 32'h0;
        end else if (upd_valid && !halt) begin
            idx  = int'((upd_pc >> 2) % 64);
            tag  = upd_pc >> 8;
            m_bc = m_bc + 32'd1;
            if (upd_taken != upd_pred) m_mc = m_mc + 32'd1;
            if (m_valid[idx] && m_tag[idx] == tag) begin
                if (upd_taken) begin
                    m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
                    m_tgt[idx] = upd_target & 32'hFFFF_FFFC;
                end else begin
                    m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
                end
            end else if (upd_taken) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tag;
                m_tgt[idx]   = upd_target & 32'hFFFF_FFFC;
                m_ctr[idx]   = 2;
            end
        end
    end

    // Returns {taken, next_pc} as the model sees the current fetch.
    function automatic logic [32:0] model_lookup(input logic fv, input logic [31:0] pc);
        int          idx = int'((pc >> 2) % 64);
        logic [31:0] tag = pc >> 8;
        logic [31:0] seq = pc + 32'd4;
        if (fv && m_valid[idx] && m_tag[idx] == tag && m_ctr[idx] >= 2) begin
            return {1'b1, m_tgt[idx]};
        end
        return {1'b0, seq};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model-vs-DUT comparison on every falling edge.
    always @(negedge clk) begin : compare
        logic [32:0] e;
        if (cmp_en) begin
            e = model_lookup(fetch_valid, fetch_pc);
            chk("model_pred_taken",   {31'h0, pred_taken}, {31'h0, e[32]});
            chk("model_pred_next_pc", pred_next_pc,        e[31:0]);
            chk("model_branch_count", branch_count,        m_bc);
            chk("model_mispred_count", mispred_count,      m_mc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic fv, input logic [31:0] fpc,
                         input logic uv, input logic ut, input logic up,
                         input logic [31:0] upc, input logic [31:0] utgt,
                         input logic h);
        fetch_valid = fv;
        fetch_pc    = fpc;
        upd_valid   = uv;
        upd_taken   = ut;
        upd_pred    = up;
        upd_pc      = upc;
        upd_target  = utgt;
        halt        = h;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Literal expectation sampled at the next falling edge.
    task automatic expect_lit(input string name, input logic pt, input logic [31:0] npc,
                              input logic [31:0] bc, input logic [31:0] mc);
        @(negedge clk);
        chk({name, ".pred_taken"},    {31'h0, pred_taken}, {31'h0, pt});
        chk({name, ".pred_next_pc"},  pred_next_pc,        npc);
        chk({name, ".branch_count"},  branch_count,        bc);
        chk({name, ".mispred_count"}, mispred_count,       mc);
    endtask

    function automatic logic [31:0] pick_pc(input int unsigned sel);
        case (sel)
            0:       return 32'h0000_0100;
            1:       return 32'h0000_0200;
            2:       return 32'h0000_0104;
            3:       return 32'h0000_0108;
            4:       return 32'h0000_0300;
            default: return 32'h0000_1100;
        endcase
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        cmp_en = 1'b1;

        // Reset state, while asserted and after release.
        expect_lit("reset_held", 1'b0, 32'h104, 0, 0);
        tick();
        rst = 1'b0;
        expect_lit("reset_released", 1'b0, 32'h104, 0, 0);
        tick();

        // Same-cycle update and lookup from empty: pre-update view, then trained.
        drive(1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 1'b0);
        expect_lit("same_cycle", 1'b0, 32'h104, 0, 0);
        tick();
        drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        expect_lit("trained", 1'b1, 32'h80, 1, 1);
        tick();

        // Two not-taken: WT -> WNT -> SNT.
        drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 1'b0);
        tick();
        tick();
        drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        expect_lit("two_not_taken", 1'b0, 32'h104, 3, 3);
        tick();

        // Third not-taken holds at SNT; a taken step then reaches WNT only.
        drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0);
        tick();
        drive(1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 32'h100, 32'h40, 1'b0);
        tick();
        drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        expect_lit("sat_low", 1'b0, 32'h104, 5, 4);
        tick();

        // One more taken -> WT with retargeted entry.
        drive(1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 32'h100, 32'h40, 1'b0);
        tick();
        drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        expect_lit("retarget", 1'b1, 32'h40, 6, 5);
        tick();

        // Two taken saturate at ST; one not-taken leaves WT (still taken).
        drive(1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 32'h100, 32'h40, 1'b0);
        tick();
        tick();
        drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 1'b0);
        tick();
        drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        expect_lit("sat_high", 1'b1, 32'h40, 9, 6);
        tick();

        // Alias at index 0: 0x200 overwrites 0x100.
        drive(1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 32'h200, 32'h300, 1'b0);
        tick();
        drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        expect_lit("alias_old", 1'b0, 32'h104, 10, 7);
        tick();
        drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        expect_lit("alias_new", 1'b1, 32'h300, 10, 7);
        tick();

        // No fetch -> no prediction even on a trained PC; sequential PC wraps.
        drive(1'b0, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        expect_lit("fetch_invalid", 1'b0, 32'h204, 10, 7);
        tick();
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        expect_lit("pc_wrap", 1'b0, 32'h0, 10, 7);
        tick();

        // Halt blocks training and counting; lookup keeps working.
        drive(1'b1, 32'h104, 1'b1, 1'b1, 1'b0, 32'h104, 32'h500, 1'b1);
        tick();
        drive(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        expect_lit("halt_blocks", 1'b0, 32'h108, 10, 7);
        tick();
        drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        expect_lit("halt_lookup", 1'b1, 32'h300, 10, 7);
        tick();

        // Not-taken miss does not allocate; taken miss allocates weakly taken.
        drive(1'b1, 32'h108, 1'b1, 1'b0, 1'b1, 32'h108, 32'h0, 1'b0);
        tick();
        drive(1'b1, 32'h108, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        expect_lit("miss_not_taken", 1'b0, 32'h10C, 11, 8);
        tick();
        drive(1'b1, 32'h108, 1'b1, 1'b1, 1'b0, 32'h108, 32'h10, 1'b0);
        tick();
        drive(1'b1, 32'h108, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        expect_lit("alloc_taken", 1'b1, 32'h10, 12, 9);
        tick();
        drive(1'b1, 32'h108, 1'b1, 1'b0, 1'b1, 32'h108, 32'h0, 1'b0);
        tick();
        drive(1'b1, 32'h108, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        expect_lit("alloc_is_weak", 1'b0, 32'h10C, 13, 10);
        tick();

        // Mixed traffic over a few aliasing PCs, checked against the model.
        for (int n = 0; n < 200; n++) begin
            drive(1'($urandom_range(0, 3) != 0), pick_pc($urandom_range(0, 5)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), pick_pc($urandom_range(0, 5)),
                  32'($urandom_range(0, 1023)) << 2,
                  1'($urandom_range(0, 7) == 0));
            tick();
        end

        // Reset asserted in the middle of an update cycle clears everything.
        drive(1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 32'h200, 32'h300, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        tick();
        expect_lit("reset_mid_update", 1'b0, 32'h204, 0, 0);
        rst = 1'b0;
        drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        expect_lit("after_reset", 1'b0, 32'h204, 0, 0);
        tick();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
